// File: rtl/cape_apb_gpio.sv
// APB3 GPIO controller for the cape pin banks: output/OE registers, synchronised
// inputs, and per-channel edge-detect interrupts with W1C status.
module cape_apb_gpio #(
  parameter int          N_GPIO      = 28,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] OUT_RESET   = 32'h0
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [7:0]        PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [N_GPIO-1:0] GPIO_IN,
  output logic [N_GPIO-1:0] GPIO_OUT,
  output logic [N_GPIO-1:0] GPIO_OE,
  output logic [N_GPIO-1:0] INT,
  output logic              IRQ
);

  localparam logic [5:0] IDX_DATA_OUT   = 6'd0;
  localparam logic [5:0] IDX_OE         = 6'd1;
  localparam logic [5:0] IDX_DATA_IN    = 6'd2;
  localparam logic [5:0] IDX_SET_OUT    = 6'd3;
  localparam logic [5:0] IDX_CLR_OUT    = 6'd4;
  localparam logic [5:0] IDX_INT_EN     = 6'd5;
  localparam logic [5:0] IDX_INT_POL    = 6'd6;
  localparam logic [5:0] IDX_INT_BOTH   = 6'd7;
  localparam logic [5:0] IDX_INT_STATUS = 6'd8;

  logic [5:0]        reg_idx;
  logic              access;
  logic              err;
  logic              wr;
  logic [N_GPIO-1:0] wdata;
  logic [N_GPIO-1:0] data_out_reg;
  logic [N_GPIO-1:0] oe_reg;
  logic [N_GPIO-1:0] int_en_reg;
  logic [N_GPIO-1:0] int_pol_reg;
  logic [N_GPIO-1:0] int_both_reg;
  logic [N_GPIO-1:0] int_status_reg;
  logic [N_GPIO-1:0] int_status_next;
  logic [N_GPIO-1:0] prev_reg;
  logic [N_GPIO-1:0] sync_in;
  logic [N_GPIO-1:0] rise;
  logic [N_GPIO-1:0] fall;
  logic [N_GPIO-1:0] evt;
  logic [N_GPIO-1:0] w1c;
  logic [N_GPIO-1:0] rd_val;
  logic [N_GPIO-1:0] sync_reg [SYNC_STAGES];
  logic              unused_ok;

  assign reg_idx   = PADDR[7:2];
  assign access    = PSEL & PENABLE;
  assign wdata     = PWDATA[N_GPIO-1:0];
  assign unused_ok = ^{PADDR[1:0], PWDATA};

  // Erroring accesses (unmapped, or a write to read-only DATA_IN) never reach state.
  assign err     = access & ((reg_idx > IDX_INT_STATUS) | (PWRITE & (reg_idx == IDX_DATA_IN)));
  assign wr      = access & PWRITE & ~err;
  assign PSLVERR = err;
  assign PREADY  = 1'b1;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
          sync_reg[gi] <= '0;
        end else if (gi == 0) begin
          sync_reg[gi] <= GPIO_IN;
        end else begin
          sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  endgenerate

  assign sync_in = sync_reg[SYNC_STAGES-1];
  assign rise    = sync_in & ~prev_reg;
  assign fall    = ~sync_in & prev_reg;
  assign evt     = (int_both_reg & (rise | fall)) |
                   (~int_both_reg & ((int_pol_reg & rise) | (~int_pol_reg & fall)));
  assign w1c     = (wr && reg_idx == IDX_INT_STATUS) ? wdata : '0;

  // A fresh event outranks a same-cycle clear so no edge is ever lost.
  assign int_status_next = (evt & int_en_reg) | (int_status_reg & ~w1c);

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      data_out_reg   <= OUT_RESET[N_GPIO-1:0];
      oe_reg         <= '0;
      int_en_reg     <= '0;
      int_pol_reg    <= '0;
      int_both_reg   <= '0;
      int_status_reg <= '0;
      prev_reg       <= '0;
    end else begin
      prev_reg       <= sync_in;
      int_status_reg <= int_status_next;
      if (wr) begin
        case (reg_idx)
          IDX_DATA_OUT: data_out_reg <= wdata;
          IDX_OE:       oe_reg       <= wdata;
          IDX_SET_OUT:  data_out_reg <= data_out_reg | wdata;
          IDX_CLR_OUT:  data_out_reg <= data_out_reg & ~wdata;
          IDX_INT_EN:   int_en_reg   <= wdata;
          IDX_INT_POL:  int_pol_reg  <= wdata;
          IDX_INT_BOTH: int_both_reg <= wdata;
          default:      ;
        endcase
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (reg_idx)
      IDX_DATA_OUT:   rd_val = data_out_reg;
      IDX_OE:         rd_val = oe_reg;
      IDX_DATA_IN:    rd_val = sync_in;
      IDX_INT_EN:     rd_val = int_en_reg;
      IDX_INT_POL:    rd_val = int_pol_reg;
      IDX_INT_BOTH:   rd_val = int_both_reg;
      IDX_INT_STATUS: rd_val = int_status_reg;
      default:        rd_val = '0;
    endcase
  end

  always_comb begin
    PRDATA = '0;
    if (access && !PWRITE) begin
      PRDATA[N_GPIO-1:0] = rd_val;
    end
  end

  assign GPIO_OUT = data_out_reg;
  assign GPIO_OE  = oe_reg;
  assign INT      = int_status_reg;
  assign IRQ      = |int_status_reg;

endmodule

// File: tb/tb_cape_apb_gpio.sv
// Scoreboard bench for cape_apb_gpio: stimulus queues expected APB responses and
// pin values; a negedge monitor pops and compares them as the DUT presents them.
module tb_cape_apb_gpio;

  localparam int N = 28;

  logic          PCLK;
  logic          PRESETN;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [7:0]    PADDR;
  logic [31:0]   PWDATA;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;
  logic [N-1:0]  gpio_in;
  logic [N-1:0]  gpio_out;
  logic [N-1:0]  gpio_oe;
  logic [N-1:0]  int_vec;
  logic          irq;

  typedef struct {
    string       name;
    int          id;
    logic [32:0] val;
  } exp_t;

  exp_t        apb_q[$];
  exp_t        pin_q[$];
  exp_t        e;
  logic [32:0] actual;
  logic        probe;
  logic        done_req;
  int          n_tests;
  int          n_fail;

  cape_apb_gpio #(.N_GPIO(N), .SYNC_STAGES(2), .OUT_RESET(32'h0)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .GPIO_IN(gpio_in), .GPIO_OUT(gpio_out), .GPIO_OE(gpio_oe), .INT(int_vec), .IRQ(irq)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  // Monitor: APB responses in the access phase, pin values whenever probed.
  always @(negedge PCLK) begin
    if (PRESETN && PSEL && PENABLE) begin
      actual = {PSLVERR, PRDATA};
      if (apb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_apb: got err/data %h, required nothing", actual);
      end else begin
        e = apb_q.pop_front();
        n_tests++;
        if (actual !== e.val) begin
          n_fail++;
          $display("FAIL %s: got err/data %h, required %h", e.name, actual, e.val);
        end else begin
          $display("[TB] ok %s err/data %h", e.name, actual);
        end
      end
    end
    if (probe) begin
      if (pin_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_probe: no expectation queued");
      end else begin
        e = pin_q.pop_front();
        case (e.id)
          0:       actual = {5'd0, gpio_out};
          1:       actual = {5'd0, gpio_oe};
          2:       actual = {5'd0, int_vec};
          3:       actual = {32'd0, irq};
          default: actual = {32'd0, PREADY};
        endcase
        n_tests++;
        if (actual !== e.val) begin
          n_fail++;
          $display("FAIL %s: got %h, required %h", e.name, actual, e.val);
        end else begin
          $display("[TB] ok %s = %h", e.name, actual);
        end
      end
    end
    if (done_req) begin
      n_tests++;
      if (apb_q.size() != 0 || pin_q.size() != 0) begin
        n_fail++;
        $display("FAIL leftover: got %0d/%0d unconsumed, required 0/0", apb_q.size(), pin_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  task automatic push_pin(input int id, input logic [32:0] val, input string name);
    exp_t x;
    x.name = name; x.id = id; x.val = val;
    pin_q.push_back(x);
  endtask

  // All tasks start and end at posedge+1.
  task automatic pin_chk(input int id, input logic [32:0] val, input string name);
    push_pin(id, val, name);
    probe = 1'b1;
    @(posedge PCLK); #1;
    probe = 1'b0;
  endtask

  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                          input logic [32:0] exp_val, input string name,
                          input int pid = -1, input logic [32:0] pre = '0);
    exp_t x;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
    @(posedge PCLK); #1;
    x.name = name; x.id = -1; x.val = exp_val;
    apb_q.push_back(x);
    if (pid >= 0) begin
      push_pin(pid, pre, {name, "_pre"});
      probe = 1'b1;
    end
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    probe = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; probe = 1'b0; done_req = 1'b0;
    PRESETN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; gpio_in = '0;
    repeat (3) @(posedge PCLK);
    #1 PRESETN = 1'b1;

    // 1: reset state
    for (int a = 0; a <= 8; a++) apb_xfer(1'b0, 8'(a * 4), 0, 33'h0, $sformatf("rst_rd_%02h", a * 4));
    pin_chk(0, 33'h0, "rst_gpio_out");
    pin_chk(1, 33'h0, "rst_gpio_oe");
    pin_chk(2, 33'h0, "rst_int");
    pin_chk(3, 33'h0, "rst_irq");
    pin_chk(4, 33'h1, "rst_pready");

    // 2: outputs, set/clear, one-cycle update
    apb_xfer(1'b1, 8'h04, 32'hFF,  33'h0, "wr_oe", 1, 33'h0);
    pin_chk(1, 33'hFF, "gpio_oe_ff");
    apb_xfer(1'b1, 8'h00, 32'hA5,  33'h0, "wr_data_out", 0, 33'h0);
    pin_chk(0, 33'hA5, "gpio_out_a5");
    apb_xfer(1'b1, 8'h0C, 32'h100, 33'h0, "wr_set_out", 0, 33'hA5);
    pin_chk(0, 33'h1A5, "gpio_out_set");
    apb_xfer(1'b1, 8'h10, 32'h01,  33'h0, "wr_clr_out", 0, 33'h1A5);
    pin_chk(0, 33'h1A4, "gpio_out_clr");
    apb_xfer(1'b0, 8'h0C, 0, 33'h0,   "rd_set_out");
    apb_xfer(1'b0, 8'h10, 0, 33'h0,   "rd_clr_out");
    apb_xfer(1'b0, 8'h00, 0, 33'h1A4, "rd_data_out");
    apb_xfer(1'b0, 8'h04, 0, 33'hFF,  "rd_oe");

    // 3: rising-edge interrupt on channel 0
    apb_xfer(1'b1, 8'h14, 32'h1, 33'h0, "wr_int_en");
    apb_xfer(1'b1, 8'h18, 32'h1, 33'h0, "wr_int_pol");
    gpio_in[0] = 1'b1;
    wait_cycles(4);
    pin_chk(2, 33'h1, "int0_rise");
    pin_chk(3, 33'h1, "irq_rise");
    apb_xfer(1'b1, 8'h20, 32'h1, 33'h0, "w1c_int0");
    pin_chk(2, 33'h0, "int0_cleared");
    gpio_in[0] = 1'b0;
    wait_cycles(6);
    pin_chk(2, 33'h0, "int0_fall_ignored");
    pin_chk(3, 33'h0, "irq_fall_ignored");

    // 4: both-edge channel 3, event colliding with W1C
    apb_xfer(1'b1, 8'h1C, 32'h8, 33'h0, "wr_int_both");
    apb_xfer(1'b1, 8'h14, 32'h8, 33'h0, "wr_int_en3");
    gpio_in[3] = 1'b1;
    wait_cycles(4);
    pin_chk(2, 33'h8, "int3_rise");
    apb_xfer(1'b1, 8'h20, 32'h8, 33'h0, "w1c_int3_a");
    pin_chk(2, 33'h0, "int3_clr_a");
    gpio_in[3] = 1'b0;
    wait_cycles(4);
    pin_chk(2, 33'h8, "int3_fall");
    apb_xfer(1'b1, 8'h20, 32'h8, 33'h0, "w1c_int3_b");
    pin_chk(2, 33'h0, "int3_clr_b");
    gpio_in[3] = 1'b1;
    @(posedge PCLK); #1;
    apb_xfer(1'b1, 8'h20, 32'h8, 33'h0, "w1c_collide");
    pin_chk(2, 33'h8, "int3_set_wins");
    apb_xfer(1'b1, 8'h14, 32'h0, 33'h0, "wr_int_en_off");
    apb_xfer(1'b0, 8'h20, 0, 33'h8, "status_kept_after_disable");
    apb_xfer(1'b1, 8'h20, 32'h8, 33'h0, "w1c_int3_c");
    gpio_in[3] = 1'b0;
    wait_cycles(5);
    apb_xfer(1'b0, 8'h20, 0, 33'h0, "disabled_evt_dropped");

    // 5: slave errors
    gpio_in = 28'h5A5_0000;
    wait_cycles(4);
    apb_xfer(1'b0, 8'h24, 0, {1'b1, 32'h0}, "rd_unmapped_err");
    apb_xfer(1'b1, 8'h08, 32'hFFFF, {1'b1, 32'h0}, "wr_data_in_err");
    apb_xfer(1'b0, 8'h08, 0, 33'h05A5_0000, "rd_data_in");
    apb_xfer(1'b1, 8'h40, 32'hFFFF, {1'b1, 32'h0}, "wr_unmapped_err");
    apb_xfer(1'b0, 8'h00, 0, 33'h1A4, "data_out_after_err");

    // 6: reset in the middle of a DATA_OUT write
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'h55;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    push_pin(0, 33'h0, "async_reset_gpio_out");
    probe = 1'b1;
    #1 PRESETN = 1'b0;
    @(posedge PCLK); #1;
    probe = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    wait_cycles(2);
    PRESETN = 1'b1;
    wait_cycles(1);
    pin_chk(0, 33'h0, "gpio_out_after_reset");
    pin_chk(1, 33'h0, "gpio_oe_after_reset");
    apb_xfer(1'b0, 8'h00, 0, 33'h0, "rd_data_out_write_lost");
    apb_xfer(1'b0, 8'h04, 0, 33'h0, "rd_oe_after_reset");

    done_req = 1'b1;
  end

endmodule
